// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus plus the instruction handoff to decode.
// The master side is the fetch unit; the slave side is memory and decode.
interface instr_fetch_if;
  logic        mem_read;
  logic [31:0] mem_adr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output mem_read, mem_adr, instr, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_read, mem_adr, instr, instr_pc, instr_valid,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: one instruction-memory read per fetch, valid/ready handoff to decode.
// Optional read timeout with NOP substitution is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          pc_in,
  input  logic                 fetch_en,
  input  logic                 flush,
  output logic                 pc_en,
  output logic                 fetch_error,
  instr_fetch_if.master        bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic        mem_read_q;
  logic [31:0] mem_adr_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        timeout;

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_adr     = mem_adr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // mem_read is only high in BUSY/DRAIN, so it alone qualifies the wait count.
  assign timeout = mem_read_q && !bus.mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (mem_read_q && !bus.mem_ack && !timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      mem_read_q    <= 1'b0;
      mem_adr_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      pc_en         <= 1'b0;
      fetch_error   <= 1'b0;
    end else begin
      pc_en       <= 1'b0;
      fetch_error <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_en && !flush) begin
            mem_adr_q  <= pc_in;
            mem_read_q <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            mem_read_q <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              instr_q       <= bus.mem_rdata;
              instr_pc_q    <= mem_adr_q;
              instr_valid_q <= 1'b1;
              pc_en         <= 1'b1;
              state         <= VALID;
            end
          end else if (timeout) begin
            // A flush arriving with the timeout discards the substituted NOP.
            mem_read_q  <= 1'b0;
            fetch_error <= 1'b1;
            if (flush) begin
              state <= IDLE;
            end else begin
              instr_q       <= NOP_INSTR;
              instr_pc_q    <= mem_adr_q;
              instr_valid_q <= 1'b1;
              pc_en         <= 1'b1;
              state         <= VALID;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        VALID: begin
          if (flush) begin
            instr_valid_q <= 1'b0;
            state         <= IDLE;
          end else if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            if (fetch_en) begin
              mem_adr_q  <= pc_in;
              mem_read_q <= 1'b1;
              state      <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          // DRAIN: wait out the abandoned read; its data never reaches decode.
          if (bus.mem_ack) begin
            mem_read_q <= 1'b0;
            state      <= IDLE;
          end else if (timeout) begin
            mem_read_q  <= 1'b0;
            fetch_error <= 1'b1;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
